// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one registered-read image ROM between several
// pixel-drawing requesters. Grants are combinational; returned data is routed
// back with a one-cycle rvalid. Locked requesters may hold the ROM for bursts,
// limited to MAX_BURST grants while anyone else is waiting.
module rom_arbiter #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned N_REQ      = 3,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [N_REQ-1:0]            i_req,
    input  logic [N_REQ-1:0]            i_lock,
    input  logic [N_REQ*ADDR_WIDTH-1:0] i_addr,
    output logic [N_REQ-1:0]            o_gnt,
    output logic [N_REQ-1:0]            o_rvalid,
    output logic [DATA_WIDTH-1:0]       o_rdata,
    output logic [ADDR_WIDTH-1:0]       o_rom_addr,
    input  logic [DATA_WIDTH-1:0]       i_rom_dout
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0]      r_last;
    logic                  r_owner_valid;
    logic [7:0]            r_burst_cnt;
    logic [N_REQ-1:0]      r_rvalid;
    logic [ADDR_WIDTH-1:0] r_rom_addr;

    logic [N_REQ-1:0]      w_others;
    logic                  w_hold;
    logic                  w_found;
    logic                  w_grant;
    logic [IDX_W-1:0]      w_win;
    logic [IDX_W-1:0]      w_idx;
    logic [ADDR_WIDTH-1:0] w_addr_sel;

    // Winner selection: keep the locked owner while its burst budget lasts,
    // otherwise scan upward from the requester after the last one granted.
    always_comb begin
        w_others          = i_req;
        w_others[r_last]  = 1'b0;
        w_hold            = r_owner_valid && i_req[r_last] && i_lock[r_last] &&
                            ((32'(r_burst_cnt) < MAX_BURST) || (w_others == '0));
        w_win             = r_last;
        w_found           = 1'b0;
        w_idx             = '0;
        if (w_hold) begin
            w_found = 1'b1;
        end else begin
            for (int k = 1; k <= int'(N_REQ); k++) begin
                w_idx = IDX_W'((32'(r_last) + 32'(k)) % N_REQ);
                if (!w_found && i_req[w_idx]) begin
                    w_found = 1'b1;
                    w_win   = w_idx;
                end
            end
        end
    end

    // Grant, ROM address mux and data pass-through; gnt is held off during reset.
    always_comb begin
        w_grant            = w_found && i_rst_n;
        o_gnt              = '0;
        if (w_grant) begin
            o_gnt[w_win] = 1'b1;
        end
        w_addr_sel = i_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
        o_rom_addr = w_grant ? w_addr_sel : r_rom_addr;
        o_rvalid   = r_rvalid;
        o_rdata    = i_rom_dout;
    end

    // Arbitration state, held ROM address and the one-cycle return valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last        <= IDX_W'(N_REQ - 1);
            r_owner_valid <= 1'b0;
            r_burst_cnt   <= 8'd0;
            r_rvalid      <= '0;
            r_rom_addr    <= '0;
        end else begin
            r_rvalid <= o_gnt;
            if (w_grant) begin
                r_last        <= w_win;
                r_owner_valid <= i_lock[w_win];
                r_rom_addr    <= w_addr_sel;
                if ((w_win == r_last) && r_owner_valid) begin
                    r_burst_cnt <= (r_burst_cnt == 8'hFF) ? 8'hFF : r_burst_cnt + 8'd1;
                end else begin
                    r_burst_cnt <= 8'd1;
                end
            end else begin
                r_owner_valid <= 1'b0;
                r_burst_cnt   <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios with literal
// expectations plus a randomized run compared every cycle to a behavioural model.
module tb_rom_arbiter;

    localparam int AW = 20;
    localparam int DW = 12;
    localparam int N  = 3;
    localparam int MB = 4;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic [N-1:0]    req      = '0;
    logic [N-1:0]    lock     = '0;
    logic [N*AW-1:0] addr     = '0;
    logic [DW-1:0]   rom_dout = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   rom_addr;

    int n_cmp = 0;
    int n_bad = 0;

    rom_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .N_REQ      (N),
        .MAX_BURST  (MB)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_lock     (lock),
        .i_addr     (addr),
        .o_gnt      (gnt),
        .o_rvalid   (rvalid),
        .o_rdata    (rdata),
        .o_rom_addr (rom_addr),
        .i_rom_dout (rom_dout)
    );

    always #5 clk = ~clk;

    // ROM model: registered read, rom[a] = a[11:0]
    always @(posedge clk) rom_dout <= rom_addr[11:0];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural model state
    int            m_last     = N - 1;
    bit            m_owner    = 1'b0;
    int            m_cnt      = 0;
    logic [AW-1:0] m_rom_addr = '0;
    logic [N-1:0]  m_prev_gnt = '0;
    logic [AW-1:0] m_prev_addr = '0;

    // Compare process: derive expected outputs from the arbitration rules each cycle
    always @(negedge clk) begin : model
        int            w;
        bit            others;
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        if (!rst_n) begin
            m_last = N - 1; m_owner = 1'b0; m_cnt = 0;
            m_rom_addr = '0; m_prev_gnt = '0; m_prev_addr = '0;
            check("rst_gnt", 64'(gnt), 64'(0));
            check("rst_rvalid", 64'(rvalid), 64'(0));
            check("rst_rom_addr", 64'(rom_addr), 64'(0));
        end else begin
            others = 1'b0;
            for (int i = 0; i < N; i++) if (i != m_last && req[i]) others = 1'b1;
            w = -1;
            if (m_owner && req[m_last] && lock[m_last] && (m_cnt < MB || !others)) begin
                w = m_last;
            end else begin
                for (int d = 1; d <= N; d++) begin
                    if (w < 0 && req[(m_last + d) % N]) w = (m_last + d) % N;
                end
            end
            eg = '0;
            ea = m_rom_addr;
            if (w >= 0) begin
                eg[w] = 1'b1;
                ea    = addr[w*AW +: AW];
            end
            check("gnt", 64'(gnt), 64'(eg));
            check("rom_addr", 64'(rom_addr), 64'(ea));
            check("rvalid", 64'(rvalid), 64'(m_prev_gnt));
            if (m_prev_gnt != '0) check("rdata", 64'(rdata), 64'(m_prev_addr[11:0]));
            m_prev_gnt = eg;
            if (w >= 0) begin
                m_cnt       = (w == m_last && m_owner) ? ((m_cnt < 255) ? m_cnt + 1 : 255) : 1;
                m_owner     = lock[w];
                m_last      = w;
                m_rom_addr  = ea;
                m_prev_addr = ea;
            end else begin
                m_owner = 1'b0;
                m_cnt   = 0;
            end
        end
    end

    // One cycle: drive shortly after the edge, return at the following negedge
    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] l, input logic [AW-1:0] a0);
        @(posedge clk);
        #1;
        req  = r;
        lock = l;
        addr[0 +: AW] = a0;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [N-1:0] exp_seq[10];

    initial begin
        addr[1*AW +: AW] = 20'h11111;
        addr[2*AW +: AW] = 20'h22222;
        repeat (2) @(posedge clk);
        #1;
        check("reset_gnt_lit", 64'(gnt), 64'(0));
        check("reset_rom_addr_lit", 64'(rom_addr), 64'(0));
        rst_n = 1'b1;

        // Single requester after reset
        cyc(3'b001, 3'b000, 20'h00010);
        check("single_gnt", 64'(gnt), 64'(3'b001));
        check("single_rom_addr", 64'(rom_addr), 64'(20'h00010));
        cyc(3'b000, 3'b000, 20'h00010);
        check("single_rvalid", 64'(rvalid), 64'(3'b001));
        check("single_rdata", 64'(rdata), 64'(12'h010));

        // Round-robin
        do_reset();
        exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100,
                    3'b000, 3'b000, 3'b000, 3'b000};
        for (int i = 0; i < 6; i++) begin
            cyc(3'b111, 3'b000, 20'h00100 + 20'(i));
            check("rr_gnt", 64'(gnt), 64'(exp_seq[i]));
        end

        // Locked burst with contention
        do_reset();
        exp_seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010,
                    3'b001, 3'b001, 3'b001, 3'b001, 3'b010};
        for (int i = 0; i < 10; i++) begin
            cyc(3'b011, 3'b001, 20'h00200 + 20'(i));
            check("burst_gnt", 64'(gnt), 64'(exp_seq[i]));
        end

        // Locked burst without contention
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(3'b001, 3'b001, 20'h00300 + 20'(i));
            check("solo_burst_gnt", 64'(gnt), 64'(3'b001));
        end

        // Idle hold
        do_reset();
        cyc(3'b001, 3'b000, 20'h00ABC);
        check("idle_first_gnt", 64'(gnt), 64'(3'b001));
        for (int i = 0; i < 3; i++) begin
            cyc(3'b000, 3'b000, 20'h0F0F0);
            check("idle_gnt", 64'(gnt), 64'(0));
            check("idle_rom_addr", 64'(rom_addr), 64'(20'h00ABC));
            check("idle_rvalid", 64'(rvalid), 64'((i == 0) ? 3'b001 : 3'b000));
        end

        // Reset mid-operation
        do_reset();
        for (int i = 0; i < 3; i++) cyc(3'b111, 3'b000, 20'h00400);
        @(posedge clk);
        #1;
        check("pre_rst_rvalid", 64'(rvalid), 64'(3'b100));
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt", 64'(gnt), 64'(0));
        check("async_rst_rvalid", 64'(rvalid), 64'(0));
        req = 3'b110;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_gnt", 64'(gnt), 64'(3'b010));

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            req  = N'($urandom);
            lock = ($urandom_range(0, 3) != 0) ? N'($urandom) : '0;
            for (int j = 0; j < N; j++) addr[j*AW +: AW] = AW'($urandom);
        end
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Round-robin arbiter that shares one synchronous single-port image ROM (registered read, 1-cycle latency) between several pixel-drawing requesters, for example a background draw module and overlay draw modules. The arbiter sits between the draw modules and the ROM instance. It selects the ROM address each cycle and routes the returned pixel word back to the requester that issued it. Optional locked bursts let a requester stream consecutive pixels without interleaving, bounded by a fairness limit.

## Interface
- ADDR_WIDTH, 20, ROM address width
- DATA_WIDTH, 12, ROM word width (RGB444)
- N_REQ, 3, number of requesters (2..8)
- MAX_BURST, 4, maximum consecutive grants to one locked requester while others wait (1..255)

- clk  in  1  posedge clock; the same clock drives the ROM
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester read request, level
- lock  in  N_REQ  per-requester burst-hold request, meaningful only with req
- addr  in  N_REQ*ADDR_WIDTH  packed addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- gnt  out  N_REQ  one-hot grant, combinational, same cycle as req
- rvalid  out  N_REQ  one-hot, registered; rdata belongs to requester i
- rdata  out  DATA_WIDTH  copy of rom_dout
- rom_addr  out  ADDR_WIDTH  address to the ROM
- rom_dout  in  DATA_WIDTH  ROM data, valid one cycle after rom_addr is sampled

## Operation
- State:
  - last: index of the last granted requester, reset value N_REQ-1.
  - owner_valid: 1 when the previous cycle granted a request that had lock set.
  - burst_cnt: 8 bits, saturating, reset value 0.
  - rvalid register.
- Winner selection, each cycle:
  - If owner_valid, req[last] and lock[last] are all 1, the winner is last, provided burst_cnt < MAX_BURST or no other req bit is set.
  - Otherwise the winner is the first set req bit scanning from (last+1) mod N_REQ upward with wrap-around.
- gnt[winner] is 1 and all other gnt bits are 0. When req is all-zero, gnt is 0.
- rom_addr equals addr[winner] whenever any grant is made. With no grant, rom_addr holds its previous value; this needs a registered copy, reset value 0.
- On a grant:
  - last <= winner.
  - If the winner equals last and owner_valid was 1, burst_cnt <= burst_cnt+1, saturating at 255. Otherwise burst_cnt <= 1.
  - owner_valid <= lock[winner].
- On a cycle with no grant: owner_valid <= 0 and burst_cnt <= 0; last is unchanged.
- rvalid <= gnt every cycle, so rdata is the ROM word for the address granted in the previous cycle.
- Requester protocol:
  - A requester must hold req and addr until it sees gnt.
  - Deasserting req without a grant is legal; no read is issued.
  - Changing addr while gnt is high does not corrupt the grant. The value present in that cycle is the one read.
- Reset:
  - Assertion clears all state immediately. gnt is forced to 0 while rst_n is low.
  - A read in flight when reset asserts is dropped: no rvalid is produced.

## Timing
- Grant latency: 0 cycles (combinational from req, lock and state).
- Data latency: exactly 1 cycle after the grant. rvalid and rdata are valid together in cycle T+1 for a grant in cycle T.
- Throughput: one read per cycle total, back-to-back across any mix of requesters.
- Fairness:
  - Without lock, a continuously requesting requester waits at most N_REQ-1 cycles.
  - With lock, it waits at most (N_REQ-1)*MAX_BURST cycles.
- Reset values: gnt=0, rvalid=0, rom_addr=0, burst_cnt=0, last=N_REQ-1, owner_valid=0.
- rdata is not registered by the arbiter. It is a pass-through of rom_dout and is don't-care when rvalid is 0.

## Test plan
Use N_REQ=3, MAX_BURST=4, and a behavioural ROM model that returns rom[a]=a[11:0].

- **Single requester after reset:** req=001, addr0=0x00010 in cycle 0 -> gnt=001 in cycle 0, rom_addr=0x00010; rvalid=001 and rdata=0x010 in cycle 1.
- **Round-robin:** req=111 held for 6 cycles, no lock -> gnt sequence 001,010,100,001,010,100; each rvalid matches the previous cycle's gnt.
- **Locked burst with contention:** req=011, lock=001 held for 10 cycles -> gnt 001 x4, 010 x1, 001 x4, 010 x1.
- **Locked burst without contention:** req=001, lock=001 for 10 cycles -> gnt=001 every cycle; burst_cnt reaches 10 with no forced rotation.
- **Idle hold:** req=000 after a grant at 0x00ABC -> gnt=000, rom_addr stays 0x00ABC, rvalid=000 from the second idle cycle onward.
- **Reset mid-operation:** req=111 running, rst_n pulsed low asynchronously between edges -> gnt and rvalid drop to 0 immediately. After release with req=110, the first grant is 010, since last=2 and the scan starts at index 0 and skips it because req0=0.
